// File: rtl/audio_avg_filter_if.sv
// Sample bus between the microphone capture side and the moving-average filter.
// AUDIO_AVG_PEAK_EN adds the peak_clr / peak pair to the bus.
interface audio_avg_filter_if;
  logic [11:0] audio_in;
  logic        new_data;
  logic        bypass;
  logic [11:0] audio_out;
  logic        out_valid;
  logic        filled;
`ifdef AUDIO_AVG_PEAK_EN
  logic        peak_clr;
  logic [11:0] peak;

  modport master (
    output audio_in, new_data, bypass, peak_clr,
    input  audio_out, out_valid, filled, peak
  );
  modport slave (
    input  audio_in, new_data, bypass, peak_clr,
    output audio_out, out_valid, filled, peak
  );
`else
  modport master (
    output audio_in, new_data, bypass,
    input  audio_out, out_valid, filled
  );
  modport slave (
    input  audio_in, new_data, bypass,
    output audio_out, out_valid, filled
  );
`endif
endinterface

// File: rtl/audio_avg_filter.sv
// Moving-average low-pass over the last 2^DEPTH_LOG2 microphone samples, two-stage pipeline.
// Optional peak tracker enabled by defining AUDIO_AVG_PEAK_EN.
module audio_avg_filter #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst,
  audio_avg_filter_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int SUM_W = 12 + DEPTH_LOG2;

  logic                  s1_v_q, s1_v_d;
  logic [11:0]           s1_sample_q, s1_sample_d;
  logic                  s1_byp_q, s1_byp_d;
  logic [11:0]           sample_buf_q [DEPTH];
  logic [11:0]           sample_buf_d [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DEPTH_LOG2:0]   fill_cnt_q, fill_cnt_d;
  logic [11:0]           audio_out_q, audio_out_d;
  logic                  out_valid_q, out_valid_d;
  logic [11:0]           old_sample;
  logic [SUM_W-1:0]      sum_next;

  always_comb begin
    s1_v_d      = bus.new_data;
    s1_sample_d = s1_sample_q;
    s1_byp_d    = s1_byp_q;
    if (bus.new_data) begin
      s1_sample_d = bus.audio_in;
      s1_byp_d    = bus.bypass;
    end

    // Window sum drops the oldest sample as the newest one overwrites its slot.
    old_sample   = sample_buf_q[wptr_q];
    sum_next     = sum_q + SUM_W'(s1_sample_q) - SUM_W'(old_sample);

    sample_buf_d = sample_buf_q;
    wptr_d       = wptr_q;
    sum_d        = sum_q;
    fill_cnt_d   = fill_cnt_q;
    audio_out_d  = audio_out_q;
    out_valid_d  = 1'b0;

    if (s1_v_q) begin
      sample_buf_d[wptr_q] = s1_sample_q;
      wptr_d               = wptr_q + 1'b1;
      sum_d                = sum_next;
      out_valid_d          = 1'b1;
      audio_out_d          = s1_byp_q ? s1_sample_q : sum_next[SUM_W-1:DEPTH_LOG2];
      if (!fill_cnt_q[DEPTH_LOG2]) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q      <= 1'b0;
      s1_sample_q <= '0;
      s1_byp_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        sample_buf_q[i] <= '0;
      end
      wptr_q      <= '0;
      sum_q       <= '0;
      fill_cnt_q  <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_sample_q  <= s1_sample_d;
      s1_byp_q     <= s1_byp_d;
      sample_buf_q <= sample_buf_d;
      wptr_q       <= wptr_d;
      sum_q        <= sum_d;
      fill_cnt_q   <= fill_cnt_d;
      audio_out_q  <= audio_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Fill counter saturates at DEPTH, whose only set bit is the MSB.
  assign bus.audio_out = audio_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.filled    = fill_cnt_q[DEPTH_LOG2];

`ifdef AUDIO_AVG_PEAK_EN
  logic [11:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (out_valid_d && bus.peak_clr) begin
      peak_d = audio_out_d;
    end else if (out_valid_d && (audio_out_d > peak_q)) begin
      peak_d = audio_out_d;
    end else if (bus.peak_clr) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`endif

endmodule

// File: tb/tb_audio_avg_filter.sv
// Scoreboard bench for audio_avg_filter (DEPTH_LOG2=3): stimulus pushes hand-computed results,
// a negedge monitor pops and compares them. Peak checks compile in with AUDIO_AVG_PEAK_EN.
module tb_audio_avg_filter;

  typedef struct {
    logic [11:0] val;
    logic        fil;
    int          due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t head;

  audio_avg_filter_if bus_if ();

  audio_avg_filter #(.DEPTH_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] sample, input logic byp,
                                input logic [11:0] exp_val, input logic exp_fil, input int gap);
    exp_t e;
    bus_if.audio_in = sample;
    bus_if.bypass   = byp;
    bus_if.new_data = 1'b1;
    e.val = exp_val;
    e.fil = exp_fil;
    e.due = cyc + 2;
    sb.push_back(e);
    step(1);
    bus_if.new_data = 1'b0;
    step(gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(1);
    check_output(name, sb.size(), 0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  // Monitor: every out_valid must match the head of the scoreboard, on its due cycle.
  always @(negedge clk) begin
    if (bus_if.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("spurious out_valid", bus_if.out_valid, 0);
      end else begin
        head = sb.pop_front();
        check_output("audio_out", bus_if.audio_out, head.val);
        check_output("filled", bus_if.filled, head.fil);
        check_output("latency", cyc, head.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check_output("missing out_valid", bus_if.out_valid, 1);
      void'(sb.pop_front());
    end
  end

  logic [11:0] exp_full [8] = '{12'h8FF, 12'h9FF, 12'hAFF, 12'hBFF,
                                12'hCFF, 12'hDFF, 12'hEFF, 12'hFFF};
  logic [11:0] exp_alt [16] = '{12'hDFF, 12'hDFF, 12'hBFF, 12'hBFF, 12'h9FF, 12'h9FF,
                                12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF,
                                12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus_if.audio_in = '0;
    bus_if.new_data = 1'b0;
    bus_if.bypass   = 1'b0;
`ifdef AUDIO_AVG_PEAK_EN
    bus_if.peak_clr = 1'b0;
`endif
    step(3);
    check_output("reset audio_out", bus_if.audio_out, 0);
    check_output("reset out_valid", bus_if.out_valid, 0);
    check_output("reset filled", bus_if.filled, 0);
    rst = 1'b1;
    step(1);

    // Ramp-up with spaced pulses of 0x800
    for (int i = 1; i <= 8; i++) apply_stimulus(12'h800, 1'b0, 12'(i * 256), i == 8, 3);
    // Full scale: window walks from 0x800 to 0xFFF
    for (int i = 0; i < 8; i++) apply_stimulus(12'hFFF, 1'b0, exp_full[i], 1'b1, 3);
    // Alternating 0x000 / 0xFFF across two pointer wraps
    for (int i = 0; i < 16; i++)
      apply_stimulus((i % 2 == 1) ? 12'hFFF : 12'h000, 1'b0, exp_alt[i], 1'b1, 1);
    drain("drain spaced");

    // Back-to-back after reset reproduces the spaced ramp
    reset_dut();
    check_output("filled after reset", bus_if.filled, 0);
    for (int i = 1; i <= 8; i++) apply_stimulus(12'h800, 1'b0, 12'(i * 256), i == 8, 0);
    drain("drain back-to-back");

    // Bypass passes through but still enters the window
    apply_stimulus(12'h123, 1'b1, 12'h123, 1'b1, 3);
    apply_stimulus(12'h123, 1'b0, 12'h648, 1'b1, 3);
    drain("drain bypass");

    // Reset with a sample in flight, plus a pulse during reset: neither may emerge
    bus_if.audio_in = 12'hABC;
    bus_if.new_data = 1'b1;
    step(1);
    bus_if.new_data = 1'b0;
    rst = 1'b0;
    step(1);
    check_output("midreset out_valid", bus_if.out_valid, 0);
    check_output("midreset audio_out", bus_if.audio_out, 0);
    check_output("midreset filled", bus_if.filled, 0);
    bus_if.new_data = 1'b1;
    step(1);
    bus_if.new_data = 1'b0;
    step(1);
    rst = 1'b1;
    step(3);
    check_output("post-reset out_valid", bus_if.out_valid, 0);
    check_output("post-reset audio_out", bus_if.audio_out, 0);
    apply_stimulus(12'h800, 1'b0, 12'h100, 1'b0, 3);
    drain("drain first after reset");

`ifdef AUDIO_AVG_PEAK_EN
    reset_dut();
    check_output("peak reset", bus_if.peak, 0);
    apply_stimulus(12'h100, 1'b1, 12'h100, 1'b0, 3);
    apply_stimulus(12'h400, 1'b1, 12'h400, 1'b0, 3);
    apply_stimulus(12'h200, 1'b1, 12'h200, 1'b0, 3);
    check_output("peak max", bus_if.peak, 12'h400);
    bus_if.peak_clr = 1'b1;
    step(1);
    bus_if.peak_clr = 1'b0;
    check_output("peak clear", bus_if.peak, 0);
    apply_stimulus(12'h400, 1'b1, 12'h400, 1'b0, 3);
    bus_if.audio_in = 12'h300;
    bus_if.bypass   = 1'b1;
    bus_if.new_data = 1'b1;
    sb.push_back('{val: 12'h300, fil: 1'b0, due: cyc + 2});
    step(1);
    bus_if.new_data = 1'b0;
    bus_if.peak_clr = 1'b1;
    step(1);
    bus_if.peak_clr = 1'b0;
    check_output("peak clear with output", bus_if.peak, 12'h300);
    drain("drain peak");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
